// File: rtl/qspi_mem_slave_ctrl.sv
// QSPI memory slave controller: decodes command/address/data byte streams from
// the byte shifters, serves an internal synchronous RAM and a sticky status byte.
module qspi_mem_slave_ctrl #(
  parameter int DWIDTH      = 2,
  parameter int WORD_BYTES  = 2,
  parameter int ADDR_BITS   = 13,
  parameter int ADDR_BYTES  = 2,
  parameter int DUMMY_BYTES = 1,
  parameter     INIT_FILE   = ""
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SS,
  input  logic [7:0]        RX_DATA,
  input  logic              RX_READY,
  input  logic              TX_READY,
  output logic [7:0]        TX_DATA,
  output logic [DWIDTH-1:0] DRIVE_EN,
  output logic [3:0]        state_dbg
);

  localparam int WW    = WORD_BYTES * 8;
  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [2:0] ADDR_LAST  = 3'(ADDR_BYTES - 1);
  localparam logic [2:0] DUMMY_LAST = 3'(DUMMY_BYTES - 1);
  localparam logic [2:0] WORD_LAST  = 3'(WORD_BYTES - 1);
  localparam logic [2:0] WORD_CNT   = 3'(WORD_BYTES);
  localparam logic [ADDR_BITS-1:0] ADDR_ONE = ADDR_BITS'(1);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_WR_DATA,
    S_RD_FETCH, S_RD_SEND, S_ST_SEND, S_DISCARD
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [2:0]             cnt_q, cnt_d;
  logic                   op_rd_q, op_rd_d, op_st_q, op_st_d;
  logic [WW-1:0]          wbuf_q, wbuf_d, word_q, word_d;
  logic [7:0]             tx_data_q, tx_data_d;
  logic [DWIDTH-1:0]      drive_en_q, drive_en_d;
  logic                   illegal_q, illegal_d, wrap_q, wrap_d;
  logic [WW-1:0]          rdata_q;
  logic                   mem_we, mem_re, addr_inc, to_tail, go_target;
  logic                   ill_set, wrap_set, flag_clr;
  logic [WW-1:0]          mem [DEPTH];

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    op_rd_d    = op_rd_q;
    op_st_d    = op_st_q;
    wbuf_d     = wbuf_q;
    word_d     = word_q;
    tx_data_d  = tx_data_q;
    drive_en_d = drive_en_q;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    addr_inc   = 1'b0;
    to_tail    = 1'b0;
    go_target  = 1'b0;
    ill_set    = 1'b0;
    wrap_set   = 1'b0;
    flag_clr   = 1'b0;
    if (SS) begin
      state_d    = S_IDLE;
      addr_d     = '0;
      cnt_d      = '0;
      drive_en_d = '0;
      tx_data_d  = 8'hFF;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_CMD;
        S_CMD: if (RX_READY) begin
          cnt_d = '0;
          case (RX_DATA)
            8'h01:   begin op_rd_d = 1'b0; op_st_d = 1'b0; state_d = S_ADDR; end
            8'h02:   begin op_rd_d = 1'b1; op_st_d = 1'b0; state_d = S_ADDR; end
            8'h05:   begin op_rd_d = 1'b0; op_st_d = 1'b1; to_tail = 1'b1; end
            default: begin state_d = S_DISCARD; ill_set = 1'b1; end
          endcase
        end
        S_ADDR: if (RX_READY) begin
          // MSB-first shift; truncation masks off address bits beyond ADDR_BITS.
          addr_d = ADDR_BITS'({addr_q, RX_DATA});
          cnt_d  = cnt_q + 3'd1;
          if (cnt_q == ADDR_LAST) begin
            cnt_d = '0;
            if (op_rd_q) to_tail = 1'b1;
            else         state_d = S_WR_DATA;
          end
        end
        S_DUMMY: if (RX_READY) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == DUMMY_LAST) go_target = 1'b1;
        end
        S_WR_DATA: if (RX_READY) begin
          wbuf_d = (wbuf_q >> 8) | (WW'(RX_DATA) << (WW - 8));
          cnt_d  = cnt_q + 3'd1;
          if (cnt_q == WORD_LAST) begin
            mem_we   = 1'b1;
            addr_inc = 1'b1;
            cnt_d    = '0;
          end
        end
        S_RD_FETCH: begin
          // Phase 0 fetches the first word; phase 1 loads it and prefetches the next.
          mem_re   = 1'b1;
          addr_inc = 1'b1;
          cnt_d    = 3'd1;
          if (cnt_q != 3'd0) begin
            tx_data_d  = rdata_q[7:0];
            word_d     = rdata_q >> 8;
            drive_en_d = '1;
            state_d    = S_RD_SEND;
          end
        end
        S_RD_SEND: if (TX_READY) begin
          if (cnt_q == WORD_CNT) begin
            tx_data_d = rdata_q[7:0];
            word_d    = rdata_q >> 8;
            cnt_d     = 3'd1;
            mem_re    = 1'b1;
            addr_inc  = 1'b1;
          end else begin
            tx_data_d = word_q[7:0];
            word_d    = word_q >> 8;
            cnt_d     = cnt_q + 3'd1;
          end
        end
        default: ;
      endcase
      if (to_tail) begin
        if (DUMMY_BYTES == 0) go_target = 1'b1;
        else begin
          state_d = S_DUMMY;
          cnt_d   = '0;
        end
      end
      if (go_target) begin
        cnt_d = '0;
        if (op_st_d) begin
          state_d    = S_ST_SEND;
          tx_data_d  = {illegal_q, wrap_q, 6'b0};
          drive_en_d = '1;
          flag_clr   = 1'b1;
        end else begin
          state_d = S_RD_FETCH;
        end
      end
      if (addr_inc) begin
        addr_d   = addr_q + ADDR_ONE;
        wrap_set = &addr_q;
      end
    end
    // A flag raised in the same cycle as the status snapshot survives the clear.
    illegal_d = (illegal_q & ~flag_clr) | ill_set;
    wrap_d    = (wrap_q & ~flag_clr) | wrap_set;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      op_rd_q    <= 1'b0;
      op_st_q    <= 1'b0;
      wbuf_q     <= '0;
      word_q     <= '0;
      tx_data_q  <= 8'hFF;
      drive_en_q <= '0;
      illegal_q  <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      op_rd_q    <= op_rd_d;
      op_st_q    <= op_st_d;
      wbuf_q     <= wbuf_d;
      word_q     <= word_d;
      tx_data_q  <= tx_data_d;
      drive_en_q <= drive_en_d;
      illegal_q  <= illegal_d;
      wrap_q     <= wrap_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we && !RST) mem[addr_q] <= wbuf_d;
    if (mem_re) rdata_q <= mem[addr_q];
  end

  assign TX_DATA   = tx_data_q;
  assign DRIVE_EN  = drive_en_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_qspi_mem_slave_ctrl.sv
// Bench for qspi_mem_slave_ctrl: directed vector table, hand-written corner
// sequences and randomized transactions checked against a transaction model.
module tb_qspi_mem_slave_ctrl;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_WR_DATA  = 4'd4;
  localparam logic [3:0] ST_RD_FETCH = 4'd5;
  localparam logic [3:0] ST_RD_SEND  = 4'd6;
  localparam logic [3:0] ST_ST_SEND  = 4'd7;
  localparam logic [3:0] ST_DISCARD  = 4'd8;
  localparam int NV = 14;

  logic       clk, rst, ss, rx_ready, tx_ready;
  logic [7:0] rx_data, tx_data;
  logic [1:0] drive_en;
  logic [3:0] state_dbg;

  int checks, errors;

  typedef struct packed {
    logic [3:0]  n_rx;
    logic [63:0] rx;
    logic [2:0]  n_tx;
    logic [31:0] exp_tx;
    logic [1:0]  exp_de;
    logic [3:0]  exp_state;
  } vec_t;

  vec_t vecs [NV];
  vec_t cur;

  // Transaction-level model of memory contents and sticky flags
  logic [15:0] mem_m [8192];
  bit          known_m [8192];
  bit          ill_m, wrap_m;

  int          kind, n, a, nx;
  logic [15:0] addr16, wd;
  logic [7:0]  b, exp_b;
  bit          ok;

  qspi_mem_slave_ctrl #(
    .DWIDTH(2), .WORD_BYTES(2), .ADDR_BITS(13), .ADDR_BYTES(2),
    .DUMMY_BYTES(1), .INIT_FILE("")
  ) dut (
    .CLK(clk), .RST(rst), .SS(ss), .RX_DATA(rx_data), .RX_READY(rx_ready),
    .TX_READY(tx_ready), .TX_DATA(tx_data), .DRIVE_EN(drive_en),
    .state_dbg(state_dbg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    rx_data  = v;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    repeat (3) tick();
  endtask

  task automatic recv_byte(input logic [7:0] exp, input bit chk);
    if (chk) begin
      check("rd_drive_en", drive_en, 2'b11);
      check("rd_byte", tx_data, exp);
    end
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    repeat (3) tick();
  endtask

  task automatic start_txn();
    ss = 1'b0;
    tick();
    tick();
  endtask

  task automatic end_txn();
    ss = 1'b1;
    tick();
    check("abort_drive_en", drive_en, 2'b00);
    check("abort_tx", tx_data, 8'hFF);
    check("abort_state", state_dbg, ST_IDLE);
    tick();
  endtask

  task automatic model_write(input int addr, input logic [15:0] w);
    mem_m[addr]   = w;
    known_m[addr] = 1'b1;
    if (addr == 8191) wrap_m = 1'b1;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    ss       = 1'b1;
    rx_ready = 1'b0;
    tx_ready = 1'b0;
    rx_data  = 8'h00;
    repeat (3) tick();
    check("reset_tx", tx_data, 8'hFF);
    check("reset_drive_en", drive_en, 2'b00);
    check("reset_state", state_dbg, ST_IDLE);
    rst = 1'b0;
    tick();

    // Directed table: bytes listed LSB-first (first byte on the bus in [7:0])
    vecs[0]  = '{4'd7, 64'h0056781234100001, 3'd0, 32'h0,        2'b00, ST_WR_DATA};
    vecs[1]  = '{4'd4, 64'h00000000A5100002, 3'd4, 32'h56781234, 2'b11, ST_RD_SEND};
    vecs[2]  = '{4'd7, 64'h0022221111FF1F01, 3'd0, 32'h0,        2'b00, ST_WR_DATA};
    vecs[3]  = '{4'd4, 64'h0000000000FF1F02, 3'd4, 32'h22221111, 2'b11, ST_RD_SEND};
    vecs[4]  = '{4'd2, 64'h0000000000003C05, 3'd1, 32'h40,       2'b11, ST_ST_SEND};
    vecs[5]  = '{4'd2, 64'h0000000000003C05, 3'd1, 32'h00,       2'b11, ST_ST_SEND};
    vecs[6]  = '{4'd4, 64'h000000000302017E, 3'd0, 32'h0,        2'b00, ST_DISCARD};
    vecs[7]  = '{4'd2, 64'h0000000000003C05, 3'd1, 32'h80,       2'b11, ST_ST_SEND};
    vecs[8]  = '{4'd5, 64'h000000ABCD200001, 3'd0, 32'h0,        2'b00, ST_WR_DATA};
    vecs[9]  = '{4'd4, 64'h00000000AA200001, 3'd0, 32'h0,        2'b00, ST_WR_DATA};
    vecs[10] = '{4'd4, 64'h0000000000200002, 3'd2, 32'hABCD,     2'b11, ST_RD_SEND};
    vecs[11] = '{4'd5, 64'h000000BEEF050001, 3'd0, 32'h0,        2'b00, ST_WR_DATA};
    vecs[12] = '{4'd4, 64'h000000000005E002, 3'd2, 32'hBEEF,     2'b11, ST_RD_SEND};
    vecs[13] = '{4'd2, 64'h0000000000003C05, 3'd1, 32'h00,       2'b11, ST_ST_SEND};

    for (int v = 0; v < NV; v++) begin
      cur = vecs[v];
      start_txn();
      for (int i = 0; i < int'(cur.n_rx); i++) send_byte(cur.rx[i*8 +: 8]);
      check($sformatf("vec%0d_drive_en", v), drive_en, cur.exp_de);
      check($sformatf("vec%0d_state", v), state_dbg, cur.exp_state);
      for (int j = 0; j < int'(cur.n_tx); j++) recv_byte(cur.exp_tx[j*8 +: 8], 1'b1);
      end_txn();
    end

    // Read latency: first byte appears two cycles after the dummy byte
    start_txn();
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h10);
    rx_data = 8'h5A; rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    check("lat_e0_drive_en", drive_en, 2'b00);
    check("lat_e0_state", state_dbg, ST_RD_FETCH);
    tick();
    check("lat_e1_drive_en", drive_en, 2'b00);
    tick();
    check("lat_e2_drive_en", drive_en, 2'b11);
    check("lat_e2_tx", tx_data, 8'h34);
    end_txn();

    // SS rising together with the completing data byte drops that byte
    start_txn();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h10); send_byte(8'h99);
    rx_data = 8'h88; rx_ready = 1'b1; ss = 1'b1;
    tick();
    rx_ready = 1'b0;
    tick();
    start_txn();
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
    recv_byte(8'h34, 1'b1);
    recv_byte(8'h12, 1'b1);
    end_txn();

    // Reset in the middle of a read clears outputs, state and flags
    start_txn(); send_byte(8'h33); end_txn();
    start_txn();
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
    recv_byte(8'h34, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_drive_en", drive_en, 2'b00);
    check("midrst_tx", tx_data, 8'hFF);
    check("midrst_state", state_dbg, ST_IDLE);
    end_txn();
    start_txn(); send_byte(8'h05); send_byte(8'h00);
    recv_byte(8'h00, 1'b1);
    end_txn();

    // Randomized transactions against the model
    ill_m  = 1'b0;
    wrap_m = 1'b0;
    for (int i = 0; i < 8192; i++) known_m[i] = 1'b0;
    for (int t = 0; t < 60; t++) begin
      kind = $urandom_range(0, 9);
      start_txn();
      if (kind <= 3) begin
        if ($urandom_range(0, 3) == 0) a = 8190 + $urandom_range(0, 1);
        else                           a = $urandom_range(256, 316);
        addr16 = 16'(a) | (16'($urandom_range(0, 7)) << 13);
        n = $urandom_range(1, 3);
        send_byte(8'h01); send_byte(addr16[15:8]); send_byte(addr16[7:0]);
        for (int w = 0; w < n; w++) begin
          wd = 16'($urandom);
          send_byte(wd[7:0]); send_byte(wd[15:8]);
          model_write(a, wd);
          a = (a + 1) % 8192;
        end
        check("rnd_wr_drive_en", drive_en, 2'b00);
      end else if (kind <= 6) begin
        a = $urandom_range(256, 316);
        n = $urandom_range(1, 3);
        addr16 = 16'(a);
        send_byte(8'h02); send_byte(addr16[15:8]); send_byte(addr16[7:0]);
        send_byte(8'($urandom));
        for (int w = 0; w < n; w++) begin
          ok = known_m[a + w];
          wd = mem_m[a + w];
          recv_byte(wd[7:0], ok);
          recv_byte(wd[15:8], ok);
        end
      end else if (kind == 7) begin
        exp_b  = {ill_m, wrap_m, 6'b0};
        ill_m  = 1'b0;
        wrap_m = 1'b0;
        send_byte(8'h05); send_byte(8'($urandom));
        recv_byte(exp_b, 1'b1);
        recv_byte(exp_b, 1'b1);
      end else if (kind == 8) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'h01 || b == 8'h02 || b == 8'h05) b = 8'hC3;
        send_byte(b);
        nx = $urandom_range(0, 3);
        for (int k = 0; k < nx; k++) send_byte(8'($urandom));
        ill_m = 1'b1;
        check("rnd_ill_drive_en", drive_en, 2'b00);
        check("rnd_ill_state", state_dbg, ST_DISCARD);
      end else begin
        a = $urandom_range(256, 316);
        addr16 = 16'(a);
        n = $urandom_range(0, 1);
        send_byte(8'h01); send_byte(addr16[15:8]); send_byte(addr16[7:0]);
        for (int w = 0; w < n; w++) begin
          wd = 16'($urandom);
          send_byte(wd[7:0]); send_byte(wd[15:8]);
          model_write(a, wd);
          a = a + 1;
        end
        send_byte(8'($urandom));
      end
      end_txn();
    end

    // Final status agrees with the model's sticky flags
    exp_b = {ill_m, wrap_m, 6'b0};
    start_txn(); send_byte(8'h05); send_byte(8'h00);
    recv_byte(exp_b, 1'b1);
    end_txn();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
